// File: rtl/fifo_pkg.sv
// Shared types and width helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } fifo_state_e;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Occupancy must represent DEPTH itself, hence the +1.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Handshake and status bundle between a FIFO producer/consumer and the FIFO.
interface fifo_sync_param_if #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 16
);
    localparam int CNT_W = fifo_pkg::cnt_w(DEPTH);

    logic             flush;
    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             rd_en;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;
    logic             rdy;

    modport master (
        output flush, din, wr_en, rd_en, clr_err,
        input  dout, full, empty, almost_full, almost_empty, count,
               overflow, underflow, rdy
    );

    modport slave (
        input  flush, din, wr_en, rd_en, clr_err,
        output dout, full, empty, almost_full, almost_empty, count,
               overflow, underflow, rdy
    );
endinterface

// File: rtl/fifo_mem_regfile.sv
// Register-file storage: one synchronous write port, one asynchronous read port.
module fifo_mem_regfile #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy, watermarks, sticky errors,
// soft flush and a post-reset memory-clear sweep that gates rdy.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 256,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 1,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic               clk,
    input  logic               rst,
    fifo_sync_param_if.slave   bus
);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    fifo_state_e      state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] clr_ptr;
    logic [CNT_W-1:0] count;
    logic             rdy;
    logic             overflow;
    logic             underflow;
    logic [WIDTH-1:0] dout_q;

    logic             full;
    logic             empty;
    logic             wr_acc;
    logic             rd_acc;
    logic             flush_run;
    logic             ovf_set;
    logic             unf_set;
    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] rd_data;

    assign full      = !rdy || (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign flush_run = bus.flush && rdy;
    assign wr_acc    = bus.wr_en && !full && !flush_run;
    assign rd_acc    = bus.rd_en && !empty && !flush_run;
    assign ovf_set   = bus.wr_en && full && rdy && !bus.flush;
    assign unf_set   = bus.rd_en && empty && rdy && !bus.flush;

    // The clear sweep borrows the single write port until the FIFO is ready.
    assign mem_we    = !rst && ((state == ST_INIT) || wr_acc);
    assign mem_waddr = (state == ST_INIT) ? clr_ptr : wr_ptr;
    assign mem_wdata = (state == ST_INIT) ? '0 : bus.din;

    fifo_mem_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            clr_ptr   <= '0;
            count     <= '0;
            rdy       <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            dout_q    <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == PTR_W'(DEPTH - 1)) begin
                        state <= ST_RUN;
                        rdy   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.flush) begin
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        count  <= '0;
                    end else begin
                        if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
                        if (rd_acc) begin
                            rd_ptr <= rd_ptr + 1'b1;
                            dout_q <= rd_data;
                        end
                        if (wr_acc && !rd_acc) begin
                            count <= count + 1'b1;
                        end else if (rd_acc && !wr_acc) begin
                            count <= count - 1'b1;
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
            // A new error event in the same cycle as clr_err must survive.
            overflow  <= ovf_set || (overflow && !bus.clr_err);
            underflow <= unf_set || (underflow && !bus.clr_err);
        end
    end

    assign bus.dout         = (FWFT != 0) ? (empty ? '0 : rd_data) : dout_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count >= CNT_W'(AF_THRESH));
    assign bus.almost_empty = (count <= CNT_W'(AE_THRESH));
    assign bus.count        = count;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;
    assign bus.rdy          = rdy;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: vector table, directed corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_fifo_sync_param;
    localparam int W = 16;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_sync_param_if #(.WIDTH(W), .DEPTH(D)) f_if ();
    fifo_sync_param_if #(.WIDTH(W), .DEPTH(D)) r_if ();

    fifo_sync_param #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_THRESH(D-2), .AE_THRESH(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (f_if)
    );

    fifo_sync_param #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_THRESH(D-2), .AE_THRESH(2)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (r_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] q[$];
    bit           m_ovf, m_unf, m_rdy;
    int           m_init_left;

    typedef struct {
        bit           w, r, f, c;
        logic [W-1:0] d;
        int           cnt;
        bit           emp, ovf, unf;
        logic [W-1:0] dout;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("count", f_if.count, q.size());
        chk("empty", f_if.empty, q.size() == 0);
        chk("full", f_if.full, !m_rdy || q.size() == D);
        chk("almost_full", f_if.almost_full, q.size() >= D - 2);
        chk("almost_empty", f_if.almost_empty, q.size() <= 2);
        chk("overflow", f_if.overflow, m_ovf);
        chk("underflow", f_if.underflow, m_unf);
        chk("rdy", f_if.rdy, m_rdy);
        if (q.size() > 0) chk("dout", f_if.dout, q[0]);
    endtask

    // One clock of the FWFT DUT: drive, advance the model, then compare.
    task automatic cyc(input bit r_st, input bit w, input bit r, input logic [W-1:0] d,
                       input bit f, input bit c);
        bit is_full, is_empty, set_o, set_u;
        rst = r_st; f_if.wr_en = w; f_if.rd_en = r; f_if.din = d;
        f_if.flush = f; f_if.clr_err = c;
        @(posedge clk);
        if (r_st) begin
            q.delete(); m_ovf = 0; m_unf = 0; m_rdy = 0; m_init_left = D;
        end else if (!m_rdy) begin
            m_init_left--;
            if (m_init_left == 0) m_rdy = 1;
        end else begin
            is_full  = (q.size() == D);
            is_empty = (q.size() == 0);
            set_o = w && is_full && !f;
            set_u = r && is_empty && !f;
            if (f) begin
                q.delete();
            end else begin
                if (r && !is_empty) void'(q.pop_front());
                if (w && !is_full) q.push_back(d);
            end
            m_ovf = set_o || (m_ovf && !c);
            m_unf = set_u || (m_unf && !c);
        end
        #1;
        chk_model();
    endtask

    task automatic cyc0(input bit w, input bit r, input logic [W-1:0] d);
        r_if.wr_en = w; r_if.rd_en = r; r_if.din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int rdy_at = -1;
        for (int k = 1; k <= 40 && rdy_at < 0; k++) begin
            cyc(0, 0, 0, '0, 0, 0);
            if (f_if.rdy) rdy_at = k;
            else chk({name, "_full"}, f_if.full, 1);
        end
        chk({name, "_latency"}, rdy_at, D);
        chk({name, "_empty"}, f_if.empty, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[12];
        int   vi;
        int   pw;

        rst = 1'b1;
        f_if.wr_en = 0; f_if.rd_en = 0; f_if.din = '0; f_if.flush = 0; f_if.clr_err = 0;
        r_if.wr_en = 0; r_if.rd_en = 0; r_if.din = '0; r_if.flush = 0; r_if.clr_err = 0;
        #1;

        // Reset and initialisation sweep
        cyc(1, 0, 0, '0, 0, 0);
        cyc(1, 0, 0, '0, 0, 0);
        chk("rst_rdy", f_if.rdy, 0);
        chk("rst_count", f_if.count, 0);
        wait_ready("init");

        // Vector table: w r f c din | count empty ovf unf dout
        tbl[0]  = '{1, 0, 0, 0, 16'hA1, 1, 0, 0, 0, 16'hA1};
        tbl[1]  = '{1, 0, 0, 0, 16'hA2, 2, 0, 0, 0, 16'hA1};
        tbl[2]  = '{1, 1, 0, 0, 16'hA3, 2, 0, 0, 0, 16'hA2};
        tbl[3]  = '{0, 1, 0, 0, 16'h00, 1, 0, 0, 0, 16'hA3};
        tbl[4]  = '{0, 1, 0, 0, 16'h00, 0, 1, 0, 0, 16'h00};
        tbl[5]  = '{0, 1, 0, 0, 16'h00, 0, 1, 0, 1, 16'h00};
        tbl[6]  = '{0, 0, 0, 1, 16'h00, 0, 1, 0, 0, 16'h00};
        tbl[7]  = '{1, 1, 0, 0, 16'hB1, 1, 0, 0, 1, 16'hB1};
        tbl[8]  = '{1, 0, 0, 1, 16'hB2, 2, 0, 0, 0, 16'hB1};
        tbl[9]  = '{1, 0, 1, 0, 16'hC0, 0, 1, 0, 0, 16'h00};
        tbl[10] = '{1, 0, 0, 0, 16'hC1, 1, 0, 0, 0, 16'hC1};
        tbl[11] = '{0, 1, 0, 0, 16'h00, 0, 1, 0, 0, 16'h00};
        for (int i = 0; i < 12; i++) begin
            cyc(0, tbl[i].w, tbl[i].r, tbl[i].d, tbl[i].f, tbl[i].c);
            chk("tbl_count", f_if.count, tbl[i].cnt);
            chk("tbl_empty", f_if.empty, tbl[i].emp);
            chk("tbl_overflow", f_if.overflow, tbl[i].ovf);
            chk("tbl_underflow", f_if.underflow, tbl[i].unf);
            if (!tbl[i].emp) chk("tbl_dout", f_if.dout, tbl[i].dout);
        end

        // Fill to full, overflow, drain, underflow, clear
        for (int i = 1; i <= 17; i++) begin
            cyc(0, 1, 0, W'(i), 0, 0);
            chk("fill_af", f_if.almost_full, i >= 14);
            chk("fill_ae", f_if.almost_empty, i <= 2);
            chk("fill_full", f_if.full, i >= 16);
            chk("fill_ovf", f_if.overflow, i == 17);
        end
        chk("fill_count", f_if.count, 16);
        for (int i = 1; i <= 16; i++) begin
            chk("drain_data", f_if.dout, i);
            cyc(0, 0, 1, '0, 0, 0);
        end
        cyc(0, 0, 1, '0, 0, 0);
        chk("drain_unf", f_if.underflow, 1);
        chk("drain_ovf_kept", f_if.overflow, 1);
        cyc(0, 0, 0, '0, 0, 1);
        chk("clr_ovf", f_if.overflow, 0);
        chk("clr_unf", f_if.underflow, 0);

        // Simultaneous read+write at count 8
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, W'(100 + i), 0, 0);
        for (int i = 0; i < 10; i++) begin
            chk("simul_data", f_if.dout, 100 + i);
            cyc(0, 1, 1, W'(108 + i), 0, 0);
            chk("simul_count", f_if.count, 8);
        end
        for (int i = 10; i < 18; i++) begin
            chk("simul_drain", f_if.dout, 100 + i);
            cyc(0, 0, 1, '0, 0, 0);
        end

        // Wrap-around streaming at occupancy 5
        cyc(0, 0, 0, '0, 1, 0);
        vi = 0;
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, W'(300 + i), 0, 0);
        for (int i = 0; i < 35; i++) begin
            chk("wrap_data", f_if.dout, 300 + vi);
            cyc(0, 1, 1, W'(305 + i), 0, 0);
            chk("wrap_count", f_if.count, 5);
            vi++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("wrap_tail", f_if.dout, 300 + vi);
            cyc(0, 0, 1, '0, 0, 0);
            vi++;
        end
        chk("wrap_empty", f_if.empty, 1);

        // Flush at count 6
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, W'(16'h500 + i), 0, 0);
        chk("flush_pre", f_if.count, 6);
        cyc(0, 0, 0, '0, 1, 0);
        chk("flush_count", f_if.count, 0);
        chk("flush_empty", f_if.empty, 1);
        chk("flush_rdy", f_if.rdy, 1);
        cyc(0, 1, 0, 16'h7777, 0, 0);
        chk("flush_next", f_if.dout, 16'h7777);
        cyc(0, 0, 1, '0, 0, 0);

        // Reset at count 6, memory must be swept to zero
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, W'(16'hF000 | i), 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, '0, 0, 0);
        chk("rst_mid_pre", f_if.count, 6);
        cyc(1, 0, 0, '0, 0, 0);
        chk("rst_mid_rdy", f_if.rdy, 0);
        wait_ready("reinit");
        for (int i = 0; i < D; i++) chk("mem_clear", u_dut.u_mem.mem[i], 0);

        // Randomized traffic with alternating write bias
        for (int blk = 0; blk < 8; blk++) begin
            pw = (blk % 2 == 0) ? 75 : 30;
            for (int k = 0; k < 200; k++) begin
                cyc(0, $urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw),
                    W'($urandom), $urandom_range(0, 127) == 0, $urandom_range(0, 31) == 0);
            end
        end

        // Registered-read build
        f_if.wr_en = 0; f_if.rd_en = 0; f_if.flush = 0; f_if.clr_err = 0;
        chk("r0_reset_dout", r_if.dout, 0);
        cyc0(1, 0, 16'hA5);
        chk("r0_write_nodout", r_if.dout, 0);
        chk("r0_count", r_if.count, 1);
        cyc0(0, 1, '0);
        chk("r0_read_dout", r_if.dout, 16'hA5);
        chk("r0_empty", r_if.empty, 1);
        cyc0(0, 0, '0);
        chk("r0_hold1", r_if.dout, 16'hA5);
        cyc0(1, 0, 16'h3C);
        chk("r0_hold2", r_if.dout, 16'hA5);
        cyc0(0, 1, '0);
        chk("r0_read2", r_if.dout, 16'h3C);
        cyc0(0, 1, '0);
        chk("r0_unf", r_if.underflow, 1);
        chk("r0_hold3", r_if.dout, 16'h3C);
        cyc0(0, 0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO, successor to the fixed 256x16 buffer in the ISFET readout DDR3/PCIe datapath. Width, depth, read mode and watermark thresholds are configurable. Adds occupancy count, almost-full/almost-empty flags, sticky overflow/underflow flags, soft flush, and a post-reset memory-clear sweep that gates rdy. Sits between sensor-frame packing and the DDR3/PCIe write engines.

Parameters:
WIDTH, 256, data width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
FWFT, 1, 1 = first-word-fall-through read, 0 = standard registered read
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  soft clear of pointers/count, no memory sweep
din  in  WIDTH  write data
wr_en  in  1  write request
rd_en  in  1  read request
clr_err  in  1  clears overflow/underflow
dout  out  WIDTH  read data
full  out  1  write not accepted
empty  out  1  read not accepted
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky: write attempted while full and rdy
underflow  out  1  sticky: read attempted while empty
rdy  out  1  FIFO initialised and usable

Behaviour:
- Interface fixed: one clock (clk); reset rst is synchronous, active-high.
- States: INIT, RUN. rst sampled high -> INIT; wr_ptr=rd_ptr=0, count=0, clear pointer=0, dout=0, rdy=0, overflow=underflow=0.
- INIT: one memory entry written to 0 per cycle, addresses 0..DEPTH-1; after the DEPTH-th clear write -> RUN, rdy=1 on the following edge. First write accepted DEPTH+1 cycles after rst deasserts.
- full = !rdy || (count==DEPTH). empty = (count==0). full is high throughout INIT.
- Write accepted iff wr_en && !full. Read accepted iff rd_en && !empty. Rejected requests have no effect on data/pointers.
- Simultaneous accepted read+write: count unchanged, both pointers advance. At full, read accepted and write rejected; at empty, write accepted and read rejected.
- Pointers are $clog2(DEPTH) bits and wrap naturally DEPTH-1 -> 0.
- FWFT=1: dout = mem[rd_ptr] combinationally whenever !empty; empty falls the edge after a write into an empty FIFO; rd_en pops the displayed word. dout is don't-care while empty.
- FWFT=0: dout is registered; it updates on the edge where a read is accepted (data valid the cycle after rd_en); it holds otherwise.
- almost_full and almost_empty are derived combinationally from count.
- overflow set when wr_en && full && rdy; underflow set when rd_en && empty && rdy. Both hold until clr_err or rst. If set and clr_err occur in the same cycle, set wins.
- flush (RUN only): pointers=0, count=0, memory untouched, rdy stays 1, error flags kept; wr_en/rd_en in the same cycle are ignored. flush during INIT is ignored.
- Priority: rst > flush > normal operation. rst mid-operation discards contents and restarts INIT.

Decomposition:
- fifo_pkg: state enum (INIT, RUN); helper function for count/pointer widths.
- Sub-module fifo_mem_regfile: WIDTH x DEPTH array with one synchronous write port and one asynchronous read port. Controller muxes in clear-sweep writes during INIT.

Test Plan:
- Reset/init: rst high 2 cycles, then low -> rdy=0, full=1 for 16 cycles; rdy=1 on cycle 17; count=0, empty=1.
- Fill/overflow (DEPTH=16): write 1..17 back-to-back -> full after 16th write, count=16, almost_full from count 14, overflow=1 after 17th; read back 1..16 in order, then one extra rd_en -> underflow=1; clr_err clears both.
- Simultaneous access: hold count=8, assert wr_en+rd_en for 10 cycles -> count stays 8, output sequence unbroken.
- Wrap-around: stream 40 incrementing words at a steady occupancy of about 5 -> all 40 read in order, no loss or duplication, pointers wrap twice.
- Flush/reset mid-operation: at count=6, pulse flush -> count=0, empty=1, rdy stays 1, next write is read back first; at count=6, pulse rst -> INIT sweep, and after rdy rises mem reads back 0.
- FWFT=0 build: write 0xA5, assert rd_en one cycle -> dout=0xA5 exactly one cycle after rd_en, then holds.
